// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
//   seg_t                  : 7-bit active-low segment vector, index 0 = segment a ... 6 = g
//   SEG_HEX[16]            : active-low patterns for hex digits 0..F
//   SEG_BLANK              : all segments off
//   SEG_NUM_DIGITS_DEFAULT : default number of multiplexed digit positions
package seg_pkg;

  typedef logic [0:6] seg_t;

  localparam int unsigned SEG_NUM_DIGITS_DEFAULT = 6;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Literals are written a..g left to right, matching the [0:6] ordering of seg_t.
  localparam seg_t SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-to-segment table.
//   seg_i    : active-low segment pattern
//   nibble_o : recovered hex value (0 when the pattern is not recognised)
//   legal_o  : high when the pattern is a known hex digit (or blank, see below)
// Build option: SEG_SCAN_BLANK_EN makes the all-off pattern legal (nibble 0).
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) begin
        nibble_o = 4'(i);
        legal_o  = 1'b1;
      end
    end
`ifdef SEG_SCAN_BLANK_EN
    if (seg_i == SEG_BLANK) begin
      legal_o = 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus and reassembles the displayed hex value.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   seg_in        : active-low segments (bit 0 = a ... bit 6 = g)
//   digit_sel     : one-hot digit strobe
//   value         : last published frame, digit i in bits [4i+3:4i]
//   digit_err     : per-digit illegal-pattern flags of the last frame
//   frame_valid   : one-cycle pulse when value/digit_err update
//   busy          : a frame is partially captured
// Build option: SEG_SCAN_BLANK_EN (see seg_pattern_decode) accepts blank digits.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = SEG_NUM_DIGITS_DEFAULT,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    busy
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  seg_t                    s_seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   s_sel_q, prev_sel_q;
  logic [7:0]              stab_cnt_q, stab_cnt_d;
  logic                    armed_q, armed_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] shadow_nib_q, shadow_nib_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
  logic                    frame_valid_q, frame_valid_d;

  logic       sel_onehot, armed_pre, capture, publish;
  logic [3:0] dec_nibble;
  logic       dec_legal;

  seg_pattern_decode u_decode (
    .seg_i    (s_seg_q),
    .nibble_o (dec_nibble),
    .legal_o  (dec_legal)
  );

  assign sel_onehot = $onehot(s_sel_q);
  assign publish    = &seen_q;

  // Dwell counter: a new dwell re-arms before the capture test, so STABLE_CYCLES = 1
  // captures on the very first sample of a new pattern.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    armed_pre  = armed_q;
    if (!sel_onehot) begin
      stab_cnt_d = 8'd0;
      armed_pre  = 1'b1;
    end else if (s_seg_q == prev_seg_q && s_sel_q == prev_sel_q) begin
      stab_cnt_d = (stab_cnt_q >= StableMax) ? StableMax : stab_cnt_q + 8'd1;
    end else begin
      stab_cnt_d = 8'd1;
      armed_pre  = 1'b1;
    end
    capture = sel_onehot && armed_pre && (stab_cnt_d == StableMax);
    armed_d = armed_pre && !capture;
  end

  // Publish reads the old shadow; a capture in the same cycle lands in the next frame.
  always_comb begin
    seen_d        = seen_q;
    shadow_nib_d  = shadow_nib_q;
    shadow_err_d  = shadow_err_q;
    value_d       = value_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = 1'b0;
    if (publish) begin
      value_d       = shadow_nib_q;
      digit_err_d   = shadow_err_q;
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end
    if (capture) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (s_sel_q[i]) begin
          shadow_nib_d[4*i +: 4] = dec_nibble;
          shadow_err_d[i]        = ~dec_legal;
          seen_d[i]              = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s_seg_q       <= '0;
      s_sel_q       <= '0;
      prev_seg_q    <= '0;
      prev_sel_q    <= '0;
      stab_cnt_q    <= 8'd0;
      armed_q       <= 1'b1;
      seen_q        <= '0;
      shadow_nib_q  <= '0;
      shadow_err_q  <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      s_seg_q       <= seg_in;
      s_sel_q       <= digit_sel;
      prev_seg_q    <= s_seg_q;
      prev_sel_q    <= s_sel_q;
      stab_cnt_q    <= stab_cnt_d;
      armed_q       <= armed_d;
      seen_q        <= seen_d;
      shadow_nib_q  <= shadow_nib_d;
      shadow_err_q  <= shadow_err_d;
      value_q       <= value_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign busy        = |seen_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder (NUM_DIGITS = 6, STABLE_CYCLES = 4).
// A cycle-level reference model built from run lengths of the pin-level input history
// is checked every clock; table vectors and hand-written sequences add explicit checks.
module tb_seg_scan_decoder;

  localparam int Stable = 4;
`ifdef SEG_SCAN_BLANK_EN
  localparam logic BlankErr = 1'b0;
`else
  localparam logic BlankErr = 1'b1;
`endif

  typedef struct {
    logic [0:6] seg;
    logic [3:0] nib;
    logic       err;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [0:6]  seg_in;
  logic [5:0]  digit_sel;
  logic [23:0] value;
  logic [5:0]  digit_err;
  logic        frame_valid;
  logic        busy;

  seg_scan_decoder #(
    .NUM_DIGITS    (6),
    .STABLE_CYCLES (Stable)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .seg_in      (seg_in),
    .digit_sel   (digit_sel),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [0:6] hex_tab [16];
  logic [0:6] fpat [6];
  vec_t       vecs [18];

  // Observed frame bookkeeping
  int          fv_count = 0;
  logic [23:0] fv_value;
  logic [5:0]  fv_err;
  logic        fv_busy;

  // Reference model state
  logic [23:0] m_shadow, m_value;
  logic [5:0]  m_shadow_err, m_err, m_seen;
  logic        m_fv;
  logic        m_last_valid;
  logic [0:6]  m_last_seg;
  logic [5:0]  m_last_sel;
  int          m_run;
  logic        m_pend;
  logic [0:6]  m_pend_seg;
  int          m_pend_digit;

  function automatic void ref_decode(input logic [0:6] p, output logic [3:0] nib,
                                     output logic err);
    nib = 4'h0;
    err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (p == hex_tab[i]) begin
        nib = 4'(i);
        err = 1'b0;
      end
    end
    if (p == 7'b1111111) err = BlankErr;
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_value = '0; m_shadow_err = '0; m_err = '0; m_seen = '0;
    m_fv = 1'b0; m_last_valid = 1'b0; m_last_seg = '0; m_last_sel = '0;
    m_run = 0; m_pend = 1'b0; m_pend_seg = '0; m_pend_digit = 0;
  endtask

  // Advance the model by one clock edge at which pins (s, d) were sampled.
  task automatic model_edge(input logic [0:6] s, input logic [5:0] d);
    logic [3:0] nib;
    logic       err;
    m_fv = (m_seen == 6'h3f);
    if (m_fv) begin
      m_value = m_shadow;
      m_err   = m_shadow_err;
      m_seen  = '0;
    end
    if (m_pend) begin
      ref_decode(m_pend_seg, nib, err);
      m_shadow[4*m_pend_digit +: 4] = nib;
      m_shadow_err[m_pend_digit]    = err;
      m_seen[m_pend_digit]          = 1'b1;
    end
    if ($countones(d) != 1) begin
      m_run = 0;
      m_last_valid = 1'b0;
    end else if (m_last_valid && s == m_last_seg && d == m_last_sel) begin
      m_run++;
    end else begin
      m_run = 1;
      m_last_valid = 1'b1;
      m_last_seg = s;
      m_last_sel = d;
    end
    // A run reaches exactly Stable once per dwell, so this gives one capture per dwell.
    m_pend = ($countones(d) == 1) && (m_run == Stable);
    if (m_pend) begin
      m_pend_seg = s;
      for (int i = 0; i < 6; i++) if (d[i]) m_pend_digit = i;
    end
  endtask

  task automatic check_model(input string name);
    vectors++;
    if ({value, digit_err, frame_valid, busy} !== {m_value, m_err, m_fv, |m_seen}) begin
      miscompares++;
      $display("FAIL %s @%0t: got value=%h err=%b fv=%b busy=%b, want value=%h err=%b fv=%b busy=%b",
               name, $time, value, digit_err, frame_valid, busy, m_value, m_err, m_fv,
               |m_seen);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic cycle(input logic [0:6] s, input logic [5:0] d, input string name);
    seg_in    = s;
    digit_sel = d;
    @(posedge clock);
    #1;
    model_edge(s, d);
    check_model(name);
    if (frame_valid) begin
      fv_count++;
      fv_value = value;
      fv_err   = digit_err;
      fv_busy  = busy;
    end
  endtask

  task automatic hold(input logic [0:6] s, input int d, input int n, input string name);
    logic [5:0] sel;
    sel = 6'(1) << d;
    for (int k = 0; k < n; k++) cycle(s, sel, name);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(7'b1111111, 6'h00, "idle");
  endtask

  task automatic run_frame(input int n, input string name);
    for (int d = 0; d < 6; d++) hold(fpat[d], d, n, name);
  endtask

  task automatic do_reset(input int n);
    seg_in    = '0;
    digit_sel = '0;
    resetn    = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    repeat (n) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic set_std_frame();
    for (int d = 0; d < 6; d++) fpat[d] = hex_tab[d+1];
  endtask

  initial begin
    int fv0;
    hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    for (int i = 0; i < 16; i++) vecs[i] = '{hex_tab[i], 4'(i), 1'b0};
    vecs[16] = '{7'b1010101, 4'h0, 1'b1};
    vecs[17] = '{7'b1111111, 4'h0, BlankErr};

    resetn = 1'b1;
    seg_in = '0;
    digit_sel = '0;
    fv_value = '0; fv_err = '0; fv_busy = 1'b0;
    model_reset();
    do_reset(2);
    check_eq("reset_value", 32'(value), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);

    // Full frame, no errors
    set_std_frame();
    fv0 = fv_count;
    run_frame(Stable, "full_frame");
    idle(4);
    check_eq("full_fv_count", 32'(fv_count - fv0), 32'd1);
    check_eq("full_value", 32'(fv_value), 32'h654321);
    check_eq("full_err", 32'(fv_err), 32'h0);
    check_eq("full_busy_at_fv", 32'(fv_busy), 32'h0);

    // Illegal pattern on digit 2
    fpat[2] = 7'b1010101;
    fv0 = fv_count;
    run_frame(Stable, "illegal");
    idle(4);
    check_eq("illegal_fv_count", 32'(fv_count - fv0), 32'd1);
    check_eq("illegal_value", 32'(fv_value), 32'h654021);
    check_eq("illegal_err", 32'(fv_err), 32'b000100);

    // Blank on digit 5
    set_std_frame();
    fpat[5] = 7'b1111111;
    run_frame(Stable, "blank");
    idle(4);
    check_eq("blank_value", 32'(fv_value), 32'h054321);
    check_eq("blank_err", 32'(fv_err), {26'd0, BlankErr, 5'b00000});

    // Short dwell, then a long dwell completing the frame
    set_std_frame();
    do_reset(1);
    fv0 = fv_count;
    hold(fpat[0], 0, Stable - 1, "short_dwell");
    for (int d = 1; d < 6; d++) hold(fpat[d], d, Stable, "short_rest");
    idle(4);
    check_eq("short_no_fv", 32'(fv_count - fv0), 32'd0);
    check_eq("short_busy", 32'(busy), 32'd1);
    hold(fpat[0], 0, 20, "long_dwell");
    check_eq("long_fv_count", 32'(fv_count - fv0), 32'd1);
    check_eq("long_value", 32'(fv_value), 32'h654321);
    check_eq("long_no_recapture", 32'(busy), 32'd0);

    // Bad selects never capture
    do_reset(1);
    fv0 = fv_count;
    for (int k = 0; k < 10; k++) cycle(hex_tab[7], 6'b000000, "sel_zero");
    for (int k = 0; k < 10; k++) cycle(hex_tab[7], 6'b000011, "sel_multi");
    idle(2);
    check_eq("badsel_busy", 32'(busy), 32'd0);
    check_eq("badsel_fv", 32'(fv_count - fv0), 32'd0);

    // Reset mid-frame discards the partial capture
    do_reset(1);
    fv0 = fv_count;
    for (int d = 0; d < 4; d++) hold(fpat[d], d, Stable, "pre_reset");
    idle(2);
    check_eq("midreset_busy_before", 32'(busy), 32'd1);
    do_reset(1);
    for (int d = 4; d < 6; d++) hold(fpat[d], d, Stable, "post_reset");
    idle(4);
    check_eq("midreset_no_fv", 32'(fv_count - fv0), 32'd0);
    check_eq("midreset_busy", 32'(busy), 32'd1);
    check_eq("midreset_value", 32'(value), 32'h0);

    // Table vectors: each pattern shown on all six digits
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < 6; d++) fpat[d] = vecs[i].seg;
      fv0 = fv_count;
      run_frame(Stable, "table");
      idle(3);
      check_eq($sformatf("table%0d_fv", i), 32'(fv_count - fv0), 32'd1);
      check_eq($sformatf("table%0d_value", i), 32'(fv_value), 32'({6{vecs[i].nib}}));
      check_eq($sformatf("table%0d_err", i), 32'(fv_err), 32'({6{vecs[i].err}}));
    end

    // Randomized scan traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [0:6] p;
      logic [5:0] sel;
      int         len;
      if ($urandom_range(0, 9) < 7) p = hex_tab[$urandom_range(0, 15)];
      else p = 7'($urandom);
      if ($urandom_range(0, 19) < 17) sel = 6'(1) << $urandom_range(0, 5);
      else sel = 6'($urandom);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) cycle(p, sel, "random");
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
